// File: rtl/csi2tx_sensor_fifo_if.sv
// Bus bundle between the CSI-2 TX packet interface, the sensor FIFO and the
// lane distributor: write stream, read stream, flush/clear controls and status.
interface csi2tx_sensor_fifo_if #(
    parameter int unsigned ADDR_W = 4
);
    logic                tinit_start_byteclkhs;
    logic                forcetxstopmode;
    logic                err_clr;
    logic [63:0]         byte_aligned_data;
    logic                byte_aligned_data_valid;
    logic                fifo_rd_en;
    logic [63:0]         fifo_rd_data;
    logic                fifo_rd_data_valid;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_almost_full;
    logic [ADDR_W:0]     fifo_level;
    logic                fifo_overflow;
    logic                fifo_underflow;

    // Producer/consumer side (packet interface + lane distributor)
    modport master (
        output tinit_start_byteclkhs,
        output forcetxstopmode,
        output err_clr,
        output byte_aligned_data,
        output byte_aligned_data_valid,
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_data_valid,
        input  fifo_empty,
        input  fifo_full,
        input  fifo_almost_full,
        input  fifo_level,
        input  fifo_overflow,
        input  fifo_underflow
    );

    // FIFO side
    modport slave (
        input  tinit_start_byteclkhs,
        input  forcetxstopmode,
        input  err_clr,
        input  byte_aligned_data,
        input  byte_aligned_data_valid,
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_data_valid,
        output fifo_empty,
        output fifo_full,
        output fifo_almost_full,
        output fifo_level,
        output fifo_overflow,
        output fifo_underflow
    );
endinterface

// File: rtl/csi2tx_sensor_fifo.sv
// Single-clock 64-bit word FIFO between the CSI-2 TX packet interface and the
// lane distributor. Registered read data (1-cycle latency, no fall-through),
// almost-full flow control, sticky overflow/underflow flags.
module csi2tx_sensor_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AF_MARGIN = 4
) (
    input  logic                     txbyteclkhs,
    input  logic                     txbyteclkhs_rst_n,
    csi2tx_sensor_fifo_if.slave      fifo_if
);

    localparam int unsigned     CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [63:0]       rd_data_q;
    logic              rd_valid_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              flush_c;
    logic              empty_c;
    logic              full_c;
    logic              rd_acc_c;
    logic              wr_acc_c;
    logic              ovf_evt_c;
    logic              unf_evt_c;

    // Accept/drop decode; a flush cycle swallows reads, writes and their errors
    always_comb begin
        flush_c   = !fifo_if.tinit_start_byteclkhs || fifo_if.forcetxstopmode;
        empty_c   = (count == '0);
        full_c    = (count == FULL_CNT);
        rd_acc_c  = fifo_if.fifo_rd_en && !empty_c && !flush_c;
        wr_acc_c  = fifo_if.byte_aligned_data_valid && (!full_c || rd_acc_c) && !flush_c;
        ovf_evt_c = fifo_if.byte_aligned_data_valid && full_c && !rd_acc_c && !flush_c;
        unf_evt_c = fifo_if.fifo_rd_en && empty_c && !flush_c;
    end

    // Storage array, deliberately not reset
    always_ff @(posedge txbyteclkhs) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= fifo_if.byte_aligned_data;
        end
    end

    // Pointers, occupancy and registered read port
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_data_q  <= 64'h0;
            rd_valid_q <= 1'b0;
        end else if (flush_c) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc_c;
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc_c) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a coincident clear
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_evt_c) begin
                overflow_q <= 1'b1;
            end else if (fifo_if.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (unf_evt_c) begin
                underflow_q <= 1'b1;
            end else if (fifo_if.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // Status is a pure decode of the registered count
    assign fifo_if.fifo_rd_data       = rd_data_q;
    assign fifo_if.fifo_rd_data_valid = rd_valid_q;
    assign fifo_if.fifo_empty         = empty_c;
    assign fifo_if.fifo_full          = full_c;
    assign fifo_if.fifo_almost_full   = (count >= AF_CNT);
    assign fifo_if.fifo_level         = count;
    assign fifo_if.fifo_overflow      = overflow_q;
    assign fifo_if.fifo_underflow     = underflow_q;

endmodule

// File: tb/tb_csi2tx_sensor_fifo.sv
// Directed bench for csi2tx_sensor_fifo: reset, fill/drain, wrap streaming,
// simultaneous read/write at the boundaries, flush and sticky error clearing.
module tb_csi2tx_sensor_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    csi2tx_sensor_fifo_if #(.ADDR_W(4)) bus ();

    csi2tx_sensor_fifo #(.DEPTH(16), .ADDR_W(4), .AF_MARGIN(4)) dut (
        .txbyteclkhs       (clk),
        .txbyteclkhs_rst_n (rst_n),
        .fifo_if           (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.byte_aligned_data_valid = 1'b0;
        bus.byte_aligned_data       = 64'h0;
        bus.fifo_rd_en              = 1'b0;
        bus.err_clr                 = 1'b0;
        bus.forcetxstopmode         = 1'b0;
        bus.tinit_start_byteclkhs   = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.fifo_empty); end
        checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
        checks++; if (bus.fifo_rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got=%0h exp=0", bus.fifo_rd_data); end
        checks++; if (bus.fifo_rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.fifo_rd_data_valid); end
        checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.fifo_full); end
        checks++; if (bus.fifo_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", bus.fifo_almost_full); end
        checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.fifo_overflow); end
        checks++; if (bus.fifo_underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", bus.fifo_underflow); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            bus.byte_aligned_data_valid = 1'b1;
            bus.byte_aligned_data       = 64'(i);
            step();
            checks++; if (bus.fifo_level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level got=%0d exp=%0d", bus.fifo_level, i + 1); end
            checks++; if (bus.fifo_almost_full !== ((i + 1) >= 12)) begin errors++; $display("FAIL fill_af level=%0d got=%b exp=%b", i + 1, bus.fifo_almost_full, ((i + 1) >= 12)); end
            checks++; if (bus.fifo_full !== ((i + 1) == 16)) begin errors++; $display("FAIL fill_full level=%0d got=%b exp=%b", i + 1, bus.fifo_full, ((i + 1) == 16)); end
        end
        bus.byte_aligned_data = 64'hDEAD;
        step();
        bus.byte_aligned_data_valid = 1'b0;
        checks++; if (bus.fifo_level !== 5'd16) begin errors++; $display("FAIL drop_level got=%0d exp=16", bus.fifo_level); end
        checks++; if (bus.fifo_overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got=%b exp=1", bus.fifo_overflow); end
        for (int i = 0; i < 16; i++) begin
            bus.fifo_rd_en = 1'b1;
            step();
            checks++; if (bus.fifo_rd_data_valid !== 1'b1) begin errors++; $display("FAIL drain_valid idx=%0d got=%b exp=1", i, bus.fifo_rd_data_valid); end
            checks++; if (bus.fifo_rd_data !== 64'(i)) begin errors++; $display("FAIL drain_data idx=%0d got=%0h exp=%0h", i, bus.fifo_rd_data, i); end
        end
        bus.fifo_rd_en = 1'b0;
        step();
        checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", bus.fifo_empty); end
        checks++; if (bus.fifo_rd_data_valid !== 1'b0) begin errors++; $display("FAIL drain_idle_valid got=%b exp=0", bus.fifo_rd_data_valid); end
        checks++; if (bus.fifo_underflow !== 1'b0) begin errors++; $display("FAIL drain_unf got=%b exp=0", bus.fifo_underflow); end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL fill_clr_ovf got=%b exp=0", bus.fifo_overflow); end
    endtask

    task automatic test_wrap();
        int exp_v = 1;
        int maxl  = 0;
        for (int c = 0; c < 50; c++) begin
            bus.byte_aligned_data_valid = (c < 40);
            bus.byte_aligned_data       = 64'(c + 1);
            bus.fifo_rd_en              = (c >= 3 && c < 43);
            step();
            if (int'(bus.fifo_level) > maxl) maxl = int'(bus.fifo_level);
            checks++; if (bus.fifo_rd_data_valid !== (c >= 3 && c < 43)) begin errors++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", c, bus.fifo_rd_data_valid, (c >= 3 && c < 43)); end
            if (bus.fifo_rd_data_valid === 1'b1) begin
                checks++; if (bus.fifo_rd_data !== 64'(exp_v)) begin errors++; $display("FAIL wrap_data cyc=%0d got=%0h exp=%0h", c, bus.fifo_rd_data, exp_v); end
                exp_v++;
            end
        end
        idle_inputs();
        checks++; if (exp_v !== 41) begin errors++; $display("FAIL wrap_count got=%0d exp=40", exp_v - 1); end
        checks++; if (maxl !== 3) begin errors++; $display("FAIL wrap_max_level got=%0d exp=3", maxl); end
        checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got=%b exp=0", bus.fifo_overflow); end
        checks++; if (bus.fifo_underflow !== 1'b0) begin errors++; $display("FAIL wrap_unf got=%b exp=0", bus.fifo_underflow); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            bus.byte_aligned_data_valid = 1'b1;
            bus.byte_aligned_data       = 64'h100 + 64'(i);
            step();
        end
        bus.byte_aligned_data = 64'hAA;
        bus.fifo_rd_en        = 1'b1;
        step();
        bus.byte_aligned_data_valid = 1'b0;
        checks++; if (bus.fifo_level !== 5'd16) begin errors++; $display("FAIL full_rw_level got=%0d exp=16", bus.fifo_level); end
        checks++; if (bus.fifo_rd_data !== 64'h100) begin errors++; $display("FAIL full_rw_data got=%0h exp=100", bus.fifo_rd_data); end
        checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL full_rw_ovf got=%b exp=0", bus.fifo_overflow); end
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++; if (bus.fifo_rd_data !== ((i == 16) ? 64'hAA : 64'h100 + 64'(i))) begin errors++; $display("FAIL full_rw_drain idx=%0d got=%0h", i, bus.fifo_rd_data); end
        end
        bus.fifo_rd_en = 1'b0;
        step();
        checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty got=%b exp=1", bus.fifo_empty); end
        bus.byte_aligned_data_valid = 1'b1;
        bus.byte_aligned_data       = 64'hBB;
        bus.fifo_rd_en              = 1'b1;
        step();
        bus.byte_aligned_data_valid = 1'b0;
        checks++; if (bus.fifo_level !== 5'd1) begin errors++; $display("FAIL empty_rw_level got=%0d exp=1", bus.fifo_level); end
        checks++; if (bus.fifo_rd_data_valid !== 1'b0) begin errors++; $display("FAIL empty_rw_valid got=%b exp=0", bus.fifo_rd_data_valid); end
        checks++; if (bus.fifo_underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_unf got=%b exp=1", bus.fifo_underflow); end
        checks++; if (bus.fifo_rd_data !== 64'hAA) begin errors++; $display("FAIL empty_rw_hold got=%0h exp=aa", bus.fifo_rd_data); end
        step();
        bus.fifo_rd_en = 1'b0;
        checks++; if (bus.fifo_rd_data !== 64'hBB) begin errors++; $display("FAIL empty_rw_read got=%0h exp=bb", bus.fifo_rd_data); end
        checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL empty_rw_final got=%0d exp=0", bus.fifo_level); end
    endtask

    task automatic test_flush();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) begin
                bus.byte_aligned_data_valid = 1'b1;
                bus.byte_aligned_data       = 64'h200 + 64'(i);
                step();
            end
            bus.byte_aligned_data_valid = 1'b0;
            bus.fifo_rd_en              = 1'b1;
            step();
            checks++; if (bus.fifo_level !== 5'd9) begin errors++; $display("FAIL flush_pre_level p=%0d got=%0d exp=9", p, bus.fifo_level); end
            checks++; if (bus.fifo_rd_data_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid p=%0d got=%b exp=1", p, bus.fifo_rd_data_valid); end
            bus.byte_aligned_data_valid = 1'b1;
            bus.byte_aligned_data       = 64'h55;
            bus.forcetxstopmode         = (p == 0);
            bus.tinit_start_byteclkhs   = (p == 0);
            step();
            idle_inputs();
            checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL flush_level p=%0d got=%0d exp=0", p, bus.fifo_level); end
            checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_empty p=%0d got=%b exp=1", p, bus.fifo_empty); end
            checks++; if (bus.fifo_rd_data_valid !== 1'b0) begin errors++; $display("FAIL flush_valid p=%0d got=%b exp=0", p, bus.fifo_rd_data_valid); end
            checks++; if (bus.fifo_rd_data !== 64'h200) begin errors++; $display("FAIL flush_hold p=%0d got=%0h exp=200", p, bus.fifo_rd_data); end
            checks++; if (bus.fifo_underflow !== 1'b1) begin errors++; $display("FAIL flush_unf p=%0d got=%b exp=1", p, bus.fifo_underflow); end
            checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf p=%0d got=%b exp=0", p, bus.fifo_overflow); end
            step();
            checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL flush_after p=%0d got=%0d exp=0", p, bus.fifo_level); end
        end
    endtask

    task automatic test_err_clr();
        for (int i = 0; i < 17; i++) begin
            bus.byte_aligned_data_valid = 1'b1;
            bus.byte_aligned_data       = (i == 16) ? 64'hDEAD : 64'h300 + 64'(i);
            step();
        end
        bus.byte_aligned_data_valid = 1'b0;
        checks++; if (bus.fifo_overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf got=%b exp=1", bus.fifo_overflow); end
        checks++; if (bus.fifo_underflow !== 1'b1) begin errors++; $display("FAIL clr_pre_unf got=%b exp=1", bus.fifo_underflow); end
        bus.err_clr = 1'b1;
        step();
        checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", bus.fifo_overflow); end
        checks++; if (bus.fifo_underflow !== 1'b0) begin errors++; $display("FAIL clr_unf got=%b exp=0", bus.fifo_underflow); end
        bus.byte_aligned_data_valid = 1'b1;
        bus.byte_aligned_data       = 64'hBEEF;
        step();
        idle_inputs();
        checks++; if (bus.fifo_overflow !== 1'b1) begin errors++; $display("FAIL clr_coincident_ovf got=%b exp=1", bus.fifo_overflow); end
        checks++; if (bus.fifo_level !== 5'd16) begin errors++; $display("FAIL clr_coincident_level got=%0d exp=16", bus.fifo_level); end
        checks++; if (bus.fifo_underflow !== 1'b0) begin errors++; $display("FAIL clr_coincident_unf got=%b exp=0", bus.fifo_underflow); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_err_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
